ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain programmer: drives the serial ccff_head input of the fabric's configuration-flip-flop chain and monitors ccff_tail.
- Accepts bitstream words over a valid/ready stream and serialises them MSB-first into the chain.
- Can optionally verify the load: it recirculates the chain through itself and compares a CRC of the returned bits against a CRC of the loaded bits.
- Sits between the bitstream source (SoC bus bridge or scan port) and the tile array's ccff_head/ccff_tail ports.

Parameters:
- CHAIN_LEN, 1024: total configuration bits in the chain (≥1).
- WORD_W, 8: input word width (≥1).
- CNT_W, 16: width of the bit counter; 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; the chain flops share this clock.
- prog_reset_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load.
- verify_en  input  1  sampled at start; 1 = run the recirculation check after the load.
- s_data  input  WORD_W  bitstream word; MSB is shifted first.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  loader accepts a word this cycle.
- ccff_head  output  1  serial data into the chain.
- chain_en  output  1  chain shift enable; chain flops capture ccff_head on a prog_clk rising edge when chain_en=1.
- ccff_tail  input  1  serial data out of the chain's last flop.
- busy  output  1  high in any state other than IDLE and DONE.
- done  output  1  load (and verify, if selected) complete; held until the next start.
- crc_ok  output  1  verify passed; valid while done=1.
- crc_err  output  1  verify mismatch; valid while done=1.
- bit_count  output  CNT_W  bits shifted in the current phase.

Behaviour:
- Reset (asynchronous, prog_reset_n=0):
  - state=IDLE.
  - s_ready, ccff_head, chain_en, busy, done, crc_ok, crc_err = 0; bit_count = 0.
  - Reset mid-load aborts immediately and chain_en drops at once. Chain contents are then undefined; software must reload.
- States: IDLE, WAIT_WORD, SHIFT, VERIFY, DONE.
- IDLE or DONE, start=1:
  - latch verify_en;
  - clear bit_count, done, crc_ok and crc_err;
  - set load CRC to 0xFFFF;
  - go to WAIT_WORD.
  - start is ignored in every other state.
- WAIT_WORD:
  - s_ready=1 (decoded from the state register); chain_en=0.
  - On s_valid&&s_ready: load the word into the shift register; nbits = min(WORD_W, CHAIN_LEN - bit_count); go to SHIFT.
- SHIFT:
  - chain_en=1; ccff_head = shift register MSB (registered).
  - Each cycle: shift left; bit_count += 1; load CRC absorbs that bit; nbits -= 1.
  - When the last bit is shifted:
    - if bit_count reaches CHAIN_LEN: go to VERIFY if verify_en was latched, else DONE;
    - otherwise go to WAIT_WORD.
  - Throughput is WORD_W bits per WORD_W+1 cycles (one WAIT_WORD cycle per word).
  - Partial last word: only its top (CHAIN_LEN mod WORD_W) bits are shifted; the low bits are discarded.
- VERIFY:
  - On entry: bit_count=0 and check CRC = 0xFFFF.
  - chain_en=1. ccff_head = ccff_tail, combinational in this state only, so the chain recirculates.
  - Each cycle the check CRC absorbs ccff_tail and bit_count += 1.
  - After CHAIN_LEN cycles the chain holds its original contents. Then crc_ok = (check CRC == load CRC) and crc_err = its complement; go to DONE.
- DONE:
  - done=1, chain_en=0, ccff_head=0, s_ready=0.
  - Without verify: crc_ok=0 and crc_err=0.
- CRC: CRC-16-CCITT, polynomial 0x1021, init 0xFFFF, one bit per cycle, no final XOR.
  - fb = crc[15]^bit; crc = {crc[14:0],1'b0} ^ (fb ? 0x1021 : 0).
- Bit order: the first bit loaded is the first bit to emerge at ccff_tail during VERIFY, so both CRCs cover the same sequence.
- Words presented beyond CHAIN_LEN bits are not consumed (s_ready=0 outside WAIT_WORD).
- s_valid low in WAIT_WORD: the loader stalls with chain_en=0 and the chain holds.

Test Plan:
- CHAIN_LEN=20, WORD_W=8, verify_en=0; words 0xA5, 0x3C, 0xF0 back-to-back. Required: the bench chain model holds 1010_0101_0011_1100_1111 (first bit deepest), chain_en is high for exactly 20 cycles, done=1, crc_ok=0, crc_err=0, 0xF0 low nibble unused.
- Same load with verify_en=1 and an ideal chain. Required: the VERIFY phase lasts 20 cycles, the chain contents after DONE equal the contents before VERIFY, crc_ok=1, crc_err=0.
- Verify with the bench flipping one chain bit between SHIFT and VERIFY. Required: crc_err=1, crc_ok=0.
- s_valid deasserted for 5 cycles between words. Required: chain_en=0 and the chain is unchanged during the gap; final contents match the first test.
- prog_reset_n asserted at bit 9. Required: all outputs 0 immediately with chain_en=0; a following start plus a full reload gives correct contents and done=1.
- start pulsed during SHIFT, and a fourth word offered after the 20th bit. Required: both ignored, s_ready stays 0, no extra chain_en cycles.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Configuration-chain programmer: serialises bitstream words MSB-first into the
// ccff chain and optionally recirculates it to compare CRC-16-CCITT signatures.
module ccff_chain_loader #(
    parameter int unsigned CHAIN_LEN = 1024,
    parameter int unsigned WORD_W    = 8,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              chain_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_ok,
    output logic              crc_err,
    output logic [CNT_W-1:0]  bit_count
);

    localparam int unsigned NB_W  = $clog2(WORD_W + 1);
    localparam int unsigned CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT = 16'hFFFF;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_WORD,
        S_SHIFT,
        S_VERIFY,
        S_DONE
    } state_t;

    state_t             r_state;
    logic               r_verify;
    logic [WORD_W-1:0]  r_shreg;
    logic [NB_W-1:0]    r_nbits;
    logic [CNT_W-1:0]   r_bit_count;
    logic [CRC_W-1:0]   r_load_crc;
    logic [CRC_W-1:0]   r_chk_crc;
    logic               r_crc_ok;
    logic               r_crc_err;

    logic [31:0]        w_remain;
    logic [NB_W-1:0]    w_take;
    logic [CRC_W-1:0]   w_load_crc_nxt;
    logic [CRC_W-1:0]   w_chk_crc_nxt;

    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] crc,
                                                   input logic             bit_in);
        logic fb;
        fb = crc[CRC_W-1] ^ bit_in;
        return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    endfunction

    // Bits still owed to the chain bound how much of the next word is shifted.
    assign w_remain       = CHAIN_LEN - 32'(r_bit_count);
    assign w_take         = (w_remain < WORD_W) ? NB_W'(w_remain) : NB_W'(WORD_W);
    assign w_load_crc_nxt = crc_step(r_load_crc, r_shreg[WORD_W-1]);
    assign w_chk_crc_nxt  = crc_step(r_chk_crc, ccff_tail);

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            r_state     <= S_IDLE;
            r_verify    <= 1'b0;
            r_shreg     <= '0;
            r_nbits     <= '0;
            r_bit_count <= '0;
            r_load_crc  <= CRC_INIT;
            r_chk_crc   <= CRC_INIT;
            r_crc_ok    <= 1'b0;
            r_crc_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_verify    <= verify_en;
                        r_bit_count <= '0;
                        r_crc_ok    <= 1'b0;
                        r_crc_err   <= 1'b0;
                        r_load_crc  <= CRC_INIT;
                        r_state     <= S_WAIT_WORD;
                    end
                end
                S_WAIT_WORD: begin
                    if (s_valid) begin
                        r_shreg <= s_data;
                        r_nbits <= w_take;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_shreg     <= r_shreg << 1;
                    r_bit_count <= r_bit_count + CNT_W'(1);
                    r_load_crc  <= w_load_crc_nxt;
                    r_nbits     <= r_nbits - NB_W'(1);
                    if (r_nbits == NB_W'(1)) begin
                        if (r_bit_count == LAST_BIT) begin
                            if (r_verify) begin
                                r_bit_count <= '0;
                                r_chk_crc   <= CRC_INIT;
                                r_state     <= S_VERIFY;
                            end else begin
                                r_state <= S_DONE;
                            end
                        end else begin
                            r_state <= S_WAIT_WORD;
                        end
                    end
                end
                S_VERIFY: begin
                    // One full lap puts every flop back where it started.
                    r_chk_crc   <= w_chk_crc_nxt;
                    r_bit_count <= r_bit_count + CNT_W'(1);
                    if (r_bit_count == LAST_BIT) begin
                        r_crc_ok  <= (w_chk_crc_nxt == r_load_crc);
                        r_crc_err <= (w_chk_crc_nxt != r_load_crc);
                        r_state   <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Stream/chain controls are pure decodes of the state register.
    assign s_ready   = (r_state == S_WAIT_WORD);
    assign chain_en  = (r_state == S_SHIFT) || (r_state == S_VERIFY);
    assign busy      = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done      = (r_state == S_DONE);
    assign ccff_head = (r_state == S_VERIFY) ? ccff_tail
                                             : ((r_state == S_SHIFT) && r_shreg[WORD_W-1]);
    assign crc_ok    = r_crc_ok;
    assign crc_err   = r_crc_err;
    assign bit_count = r_bit_count;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: behavioural chain model, table-driven loads,
// randomized loads against a bit-list reference, and reset/ignore corner cases.
module tb_ccff_chain_loader;

    localparam int CL       = 20;
    localparam int WW       = 8;
    localparam int CW       = 16;
    localparam int FLIP_BIT = 7;

    logic          prog_clk     = 1'b0;
    logic          prog_reset_n = 1'b0;
    logic          start        = 1'b0;
    logic          verify_en    = 1'b0;
    logic [WW-1:0] s_data       = '0;
    logic          s_valid      = 1'b0;
    logic          s_ready;
    logic          ccff_head;
    logic          chain_en;
    logic          ccff_tail;
    logic          busy;
    logic          done;
    logic          crc_ok;
    logic          crc_err;
    logic [CW-1:0] bit_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic [CL-1:0] chain      = '0;
    int            en_cnt     = 0;
    int            en_base    = 0;
    bit            flip_arm   = 1'b0;
    bit            arm_mid    = 1'b0;
    bit            extra_on   = 1'b0;
    int            extra_seen = 0;
    bit            snap_taken = 1'b0;
    logic [CL-1:0] pre_chain  = '0;

    typedef struct {
        logic [7:0]    w0, w1, w2;
        bit            ver, flip;
        int            gap;
        bit            mid, extra;
        logic [CL-1:0] exp_chain;
        bit            exp_ok, exp_err;
    } vec_t;

    vec_t vecs[6];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(CW)) dut (
        .prog_clk     (prog_clk),
        .prog_reset_n (prog_reset_n),
        .start        (start),
        .verify_en    (verify_en),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .chain_en     (chain_en),
        .ccff_tail    (ccff_tail),
        .busy         (busy),
        .done         (done),
        .crc_ok       (crc_ok),
        .crc_err      (crc_err),
        .bit_count    (bit_count)
    );

    // Ideal chain: flop 0 takes ccff_head, flop CL-1 drives ccff_tail.
    assign ccff_tail = chain[CL-1];

    always @(posedge prog_clk) begin
        logic [CL-1:0] c;
        c = chain;
        if (chain_en) begin
            c = {chain[CL-2:0], ccff_head};
            if (flip_arm && (en_cnt - en_base) == CL - 1) c[FLIP_BIT] = ~c[FLIP_BIT];
            en_cnt <= en_cnt + 1;
        end
        chain <= c;
    end

    task automatic check(input string tag, input string name,
                         input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", tag, name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge prog_clk);
        start = 1'b0;
        if (arm_mid && chain_en && (en_cnt - en_base) == 3) begin
            start     = 1'b1;
            verify_en = ~verify_en;
            arm_mid   = 1'b0;
        end
        if (extra_on && s_ready) extra_seen++;
        if (!snap_taken && (en_cnt - en_base) == CL) begin
            pre_chain  = chain;
            snap_taken = 1'b1;
        end
    endtask

    // Reference: concatenate the words MSB-first, keep the first CL bits;
    // the first bit ends up deepest (next to ccff_tail).
    function automatic logic [CL-1:0] model_chain(input logic [7:0] w0, w1, w2);
        bit            q[$];
        logic [7:0]    ws[3];
        logic [CL-1:0] r;
        ws[0] = w0;
        ws[1] = w1;
        ws[2] = w2;
        for (int i = 0; i < 3; i++)
            for (int b = WW - 1; b >= 0; b--) q.push_back(ws[i][b]);
        r = '0;
        for (int k = 0; k < CL; k++) r[CL-1-k] = q[k];
        return r;
    endfunction

    task automatic run_load(input vec_t v, input string tag);
        logic [7:0]    w[3];
        logic [CL-1:0] gsnap;
        logic [CL-1:0] fmask;
        int            n;
        int            gen;
        w[0]  = v.w0;
        w[1]  = v.w1;
        w[2]  = v.w2;
        fmask = v.flip ? (CL'(1) << FLIP_BIT) : '0;

        en_base    = en_cnt;
        snap_taken = 1'b0;
        extra_seen = 0;
        extra_on   = 1'b0;
        flip_arm   = v.flip;
        arm_mid    = v.mid;
        verify_en  = v.ver;
        start      = 1'b1;
        tick();
        check(tag, "start_state", 32'({busy, done, crc_ok, crc_err, s_ready}), 32'b10001);
        check(tag, "start_count", 32'(bit_count), 32'd0);

        for (int i = 0; i < 3; i++) begin
            s_data  = w[i];
            s_valid = 1'b1;
            n = 0;
            while (!s_ready && n < 100) begin tick(); n++; end
            check(tag, $sformatf("ready_w%0d", i), 32'(s_ready), 32'd1);
            tick();
            if (v.gap > 0 && i == 0) begin
                s_valid = 1'b0;
                n = 0;
                while (!s_ready && n < 100) begin tick(); n++; end
                gsnap = chain;
                gen   = 0;
                repeat (v.gap) begin tick(); if (chain_en) gen++; end
                check(tag, "gap_chain_hold", 32'(chain), 32'(gsnap));
                check(tag, "gap_en_cycles", 32'(gen), 32'd0);
                check(tag, "gap_ready", 32'(s_ready), 32'd1);
            end
        end
        if (v.extra) begin
            s_data   = 8'h55;
            s_valid  = 1'b1;
            extra_on = 1'b1;
        end else begin
            s_valid = 1'b0;
        end

        n = 0;
        while (!done && n < 300) begin tick(); n++; end
        check(tag, "done", 32'(done), 32'd1);
        repeat (3) tick();

        check(tag, "en_cycles", 32'(en_cnt - en_base), v.ver ? 32'(2 * CL) : 32'(CL));
        check(tag, "loaded_chain", 32'(pre_chain ^ fmask), 32'(v.exp_chain));
        check(tag, "final_chain", 32'(chain), 32'(pre_chain));
        check(tag, "crc_ok", 32'(crc_ok), 32'(v.exp_ok));
        check(tag, "crc_err", 32'(crc_err), 32'(v.exp_err));
        check(tag, "idle_outs", 32'({busy, s_ready, chain_en, ccff_head}), 32'd0);
        check(tag, "bit_count", 32'(bit_count), 32'(CL));
        if (v.extra) check(tag, "extra_ready_seen", 32'(extra_seen), 32'd0);

        s_valid  = 1'b0;
        extra_on = 1'b0;
        flip_arm = 1'b0;
        arm_mid  = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          rv;
        logic [CL-1:0] snap;
        int            n;

        vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 20'hA53CF, 1'b0, 1'b0};
        vecs[1] = '{8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 20'hA53CF, 1'b1, 1'b0};
        vecs[2] = '{8'hA5, 8'h3C, 8'hF0, 1'b1, 1'b1, 0, 1'b0, 1'b0, 20'hA53CF, 1'b0, 1'b1};
        vecs[3] = '{8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 5, 1'b0, 1'b0, 20'hA53CF, 1'b0, 1'b0};
        vecs[4] = '{8'hA5, 8'h3C, 8'hF0, 1'b0, 1'b0, 0, 1'b1, 1'b1, 20'hA53CF, 1'b0, 1'b0};
        vecs[5] = '{8'h0F, 8'hC3, 8'h9A, 1'b1, 1'b0, 0, 1'b1, 1'b1, 20'h0FC39, 1'b1, 1'b0};

        repeat (3) @(negedge prog_clk);
        check("reset", "outs", 32'({s_ready, ccff_head, chain_en, busy, done, crc_ok, crc_err}), 32'd0);
        check("reset", "bit_count", 32'(bit_count), 32'd0);
        prog_reset_n = 1'b1;
        tick();

        for (int t = 0; t < 6; t++) run_load(vecs[t], $sformatf("vec%0d", t));

        // Reset in the middle of the shift phase.
        verify_en = 1'b0;
        en_base   = en_cnt;
        start     = 1'b1;
        tick();
        s_data  = 8'hA5;
        s_valid = 1'b1;
        n = 0;
        while (!(chain_en && bit_count == CW'(9)) && n < 100) begin tick(); n++; end
        check("rst_mid", "reached_bit9", 32'(bit_count), 32'd9);
        snap = chain;
        prog_reset_n = 1'b0;
        #1;
        check("rst_mid", "outs", 32'({s_ready, ccff_head, chain_en, busy, done, crc_ok, crc_err}), 32'd0);
        check("rst_mid", "bit_count", 32'(bit_count), 32'd0);
        s_valid = 1'b0;
        tick();
        tick();
        check("rst_mid", "chain_hold", 32'(chain), 32'(snap));
        check("rst_mid", "chain_en", 32'(chain_en), 32'd0);
        prog_reset_n = 1'b1;
        tick();
        run_load(vecs[0], "rst_reload");

        for (int r = 0; r < 16; r++) begin
            rv.w0    = 8'($urandom);
            rv.w1    = 8'($urandom);
            rv.w2    = 8'($urandom);
            rv.ver   = 1'($urandom_range(0, 1));
            rv.flip  = rv.ver ? 1'($urandom_range(0, 1)) : 1'b0;
            rv.gap   = int'($urandom_range(0, 3));
            rv.mid   = 1'($urandom_range(0, 1));
            rv.extra = 1'($urandom_range(0, 1));
            rv.exp_chain = model_chain(rv.w0, rv.w1, rv.w2);
            rv.exp_ok    = rv.ver && !rv.flip;
            rv.exp_err   = rv.ver && rv.flip;
            run_load(rv, $sformatf("rand%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
